// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 frame sequencer: FSM state encoding,
// SSD1306 command opcodes and I2C control bytes, and the init table length.
package ssd1306_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WIN,
        ST_DATA_HDR,
        ST_FETCH,
        ST_SEND,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] DISP_OFF  = 8'hAE;
    localparam logic [7:0] DISP_ON   = 8'hAF;
    localparam logic [7:0] SET_MUX   = 8'hA8;
    localparam logic [7:0] COL_ADDR  = 8'h21;
    localparam logic [7:0] PAGE_ADDR = 8'h22;
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    // Index of DISP_ON, the final entry of the init command table.
    localparam logic [4:0] INIT_LAST_IDX = 5'd25;

endpackage

// File: rtl/ssd1306_frame_sequencer_if.sv
// Byte stream between the frame sequencer (master) and the I2C byte engine (slave).
//   tx_valid / tx_ready : handshake, a byte moves when both are high and tx_nack is low
//   tx_byte             : address, control or payload byte
//   tx_first / tx_last  : byte opens (START before it) / closes (STOP after it) a transaction
//   tx_nack             : engine saw NACK on the current byte, 1-cycle pulse
interface ssd1306_frame_sequencer_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_first;
    logic       tx_last;
    logic       tx_nack;

    modport master (output tx_valid, tx_byte, tx_first, tx_last,
                    input  tx_ready, tx_nack);
    modport slave  (input  tx_valid, tx_byte, tx_first, tx_last,
                    output tx_ready, tx_nack);
endinterface

// File: rtl/ssd1306_init_rom.sv
// SSD1306 power-up command table (command bytes only; the address and control
// bytes are emitted by the sequencer).
//   idx_i  : table index 0..25
//   byte_o : command byte at idx_i (00 beyond the table)
//   last_o : idx_i is the final entry (DISP_ON)
module ssd1306_init_rom
    import ssd1306_pkg::*;
#(
    parameter int HEIGHT = 32
) (
    input  logic [4:0] idx_i,
    output logic [7:0] byte_o,
    output logic       last_o
);
    localparam logic [7:0] MUX_RATIO = 8'(HEIGHT - 1);
    // COM pin config: sequential for 32-row panels, alternative for 64-row panels.
    localparam logic [7:0] COM_CFG   = (HEIGHT == 64) ? 8'h12 : 8'h02;

    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            5'd0:  byte_o = DISP_OFF;
            5'd1:  byte_o = 8'hD5;
            5'd2:  byte_o = 8'h80;
            5'd3:  byte_o = SET_MUX;
            5'd4:  byte_o = MUX_RATIO;
            5'd5:  byte_o = 8'hD3;
            5'd6:  byte_o = 8'h00;
            5'd7:  byte_o = 8'h40;
            5'd8:  byte_o = 8'h8D;
            5'd9:  byte_o = 8'h14;
            5'd10: byte_o = 8'h20;
            5'd11: byte_o = 8'h00;
            5'd12: byte_o = 8'hA1;
            5'd13: byte_o = 8'hC8;
            5'd14: byte_o = 8'hDA;
            5'd15: byte_o = COM_CFG;
            5'd16: byte_o = 8'h81;
            5'd17: byte_o = 8'h8F;
            5'd18: byte_o = 8'hD9;
            5'd19: byte_o = 8'hF1;
            5'd20: byte_o = 8'hDB;
            5'd21: byte_o = 8'h40;
            5'd22: byte_o = 8'hA4;
            5'd23: byte_o = 8'hA6;
            5'd24: byte_o = 8'h2E;
            5'd25: byte_o = DISP_ON;
            default: byte_o = 8'h00;
        endcase
    end

    assign last_o = (idx_i == INIT_LAST_IDX);
endmodule

// File: rtl/ssd1306_frame_sequencer.sv
// SSD1306 transaction sequencer: init (once), column/page window, then the whole
// framebuffer as one data transaction, repeated per frame in continuous mode.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, stop_req      : start pulse; continuous mode ends after the current frame
//   fb_rd_addr/fb_rd_data: framebuffer read port, 1-cycle read latency
//   tx                   : byte stream to the I2C engine (master side)
//   busy, frame_done     : sequence active; 1-cycle pulse per finished frame
//   error                : sticky NACK flag, cleared by an accepted start
//
// state    | meaning
// IDLE     | after reset, waiting for start
// INIT     | addr, ctrl 00, init command table
// WIN      | addr, ctrl 00, column and page window
// DATA_HDR | addr, ctrl 40 opening the payload transaction
// FETCH    | fb_rd_addr presented, waiting out the read latency
// SEND     | payload byte from fb_rd_data offered
// DONE     | frame(s) finished, waiting for start
// ERROR    | NACK seen, waiting for start (forces a fresh init)
module ssd1306_frame_sequencer
    import ssd1306_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = 7'h3C,
    parameter int         WIDTH      = 128,
    parameter int         HEIGHT     = 32,
    parameter bit         CONTINUOUS = 1'b0,
    parameter int         FB_AW      = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop_req,
    output logic [FB_AW-1:0]         fb_rd_addr,
    input  logic [7:0]               fb_rd_data,
    ssd1306_frame_sequencer_if.master tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     error
);
    localparam int               PAGES     = HEIGHT / 8;
    localparam int               NBYTES    = WIDTH * PAGES;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(NBYTES - 1);
    localparam logic [7:0]       ADDR_BYTE = {I2C_ADDR, 1'b0};
    localparam logic [7:0]       COL_END   = 8'(WIDTH - 1);
    localparam logic [7:0]       PAGE_END  = 8'(PAGES - 1);

    if (!(HEIGHT == 32 || HEIGHT == 64)) begin : g_bad_height
        $error("ssd1306_frame_sequencer: HEIGHT must be 32 or 64");
    end
    if ((2 ** FB_AW) < NBYTES) begin : g_bad_aw
        $error("ssd1306_frame_sequencer: FB_AW too small for WIDTH*PAGES");
    end

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic             init_done_q, init_done_d;
    logic             error_q, error_d;
    logic             frame_done_q, frame_done_d;

    logic       tx_valid_c, tx_first_c, tx_last_c, hs;
    logic [7:0] tx_byte_c, rom_byte, win_byte;
    logic       rom_last;

    // idx_q counts bytes of the current transaction; table entries start after addr+ctrl.
    ssd1306_init_rom #(.HEIGHT(HEIGHT)) u_rom (
        .idx_i  (idx_q - 5'd2),
        .byte_o (rom_byte),
        .last_o (rom_last)
    );

    always_comb begin
        win_byte = 8'h00;
        case (idx_q)
            5'd2:    win_byte = COL_ADDR;
            5'd3:    win_byte = 8'h00;
            5'd4:    win_byte = COL_END;
            5'd5:    win_byte = PAGE_ADDR;
            5'd6:    win_byte = 8'h00;
            5'd7:    win_byte = PAGE_END;
            default: win_byte = 8'h00;
        endcase
    end

    // A NACKed byte never counts as accepted.
    assign hs = tx_valid_c & tx.tx_ready & ~tx.tx_nack;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fb_addr_d    = fb_addr_q;
        init_done_d  = init_done_q;
        error_d      = error_q;
        frame_done_d = 1'b0;
        tx_valid_c   = 1'b0;
        tx_byte_c    = 8'h00;
        tx_first_c   = 1'b0;
        tx_last_c    = 1'b0;
        case (state_q)
            ST_INIT: begin
                tx_valid_c = 1'b1;
                tx_first_c = (idx_q == 5'd0);
                tx_byte_c  = (idx_q == 5'd0) ? ADDR_BYTE :
                             (idx_q == 5'd1) ? CTRL_CMD  : rom_byte;
                tx_last_c  = (idx_q >= 5'd2) && rom_last;
                if (hs) begin
                    if (tx_last_c) begin
                        init_done_d = 1'b1;
                        idx_d       = 5'd0;
                        state_d     = ST_WIN;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_WIN: begin
                tx_valid_c = 1'b1;
                tx_first_c = (idx_q == 5'd0);
                tx_byte_c  = (idx_q == 5'd0) ? ADDR_BYTE :
                             (idx_q == 5'd1) ? CTRL_CMD  : win_byte;
                tx_last_c  = (idx_q == 5'd7);
                if (hs) begin
                    if (tx_last_c) begin
                        idx_d   = 5'd0;
                        state_d = ST_DATA_HDR;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_DATA_HDR: begin
                tx_valid_c = 1'b1;
                tx_first_c = (idx_q == 5'd0);
                tx_byte_c  = (idx_q == 5'd0) ? ADDR_BYTE : CTRL_DATA;
                if (hs) begin
                    if (idx_q == 5'd1) begin
                        idx_d   = 5'd0;
                        state_d = ST_FETCH;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = fb_rd_data;
                tx_last_c  = (fb_addr_q == LAST_ADDR);
                if (hs) begin
                    if (tx_last_c) begin
                        fb_addr_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = (CONTINUOUS && !stop_req) ? ST_WIN : ST_DONE;
                    end else begin
                        fb_addr_d = fb_addr_q + FB_AW'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    error_d   = 1'b0;
                    idx_d     = 5'd0;
                    fb_addr_d = '0;
                    if (state_q == ST_ERROR || !init_done_q) begin
                        init_done_d = 1'b0;
                        state_d     = ST_INIT;
                    end else begin
                        state_d = ST_WIN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tx.tx_nack) begin
            state_d      = ST_ERROR;
            error_d      = 1'b1;
            idx_d        = 5'd0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 5'd0;
            fb_addr_q    <= '0;
            init_done_q  <= 1'b0;
            error_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fb_addr_q    <= fb_addr_d;
            init_done_q  <= init_done_d;
            error_q      <= error_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx.tx_valid = tx_valid_c;
    assign tx.tx_byte  = tx_byte_c;
    assign tx.tx_first = tx_first_c;
    assign tx.tx_last  = tx_last_c;
    assign fb_rd_addr  = fb_addr_q;
    assign frame_done  = frame_done_q;
    assign error       = error_q;
    assign busy        = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
endmodule
